// File: rtl/jx2_mem_arb.sv
// Two-requester memory arbiter for the data (A) and instruction (B) caches.
// Round-robin on ties, grant held until the memory side retires, watchdog on stalled grants.
module jx2_mem_arb #(
    parameter int TMO_LIMIT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [47:0]  reqAAddr,
    input  logic [47:0]  reqBAddr,
    input  logic [4:0]   reqAOpm,
    input  logic [4:0]   reqBOpm,
    input  logic [127:0] reqADataO,
    input  logic [127:0] reqBDataO,
    output logic [127:0] reqADataI,
    output logic [127:0] reqBDataI,
    output logic [1:0]   reqAOK,
    output logic [1:0]   reqBOK,
    output logic [47:0]  memAddr,
    output logic [4:0]   memOpm,
    output logic [127:0] memDataO,
    input  logic [127:0] memDataI,
    input  logic [1:0]   memOK
);
    // state    | meaning
    // IDLE     | no grant; memOpm held at 0, picks next requester
    // GRANT_A  | data cache owns the memory port
    // GRANT_B  | instruction cache owns the memory port
    // RELEASE  | memOpm at 0, waiting for memory to report READY
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_OK    = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;
    localparam logic [7:0] TMO_LAST = 8'(TMO_LIMIT - 1);

    state_t     state;
    state_t     nextState;
    logic       lastWin;    // 1 = B won the most recent grant
    logic [7:0] tmo;
    logic       seenOk;

    logic       reqAAct;
    logic       reqBAct;
    logic       inGrant;
    logic [4:0] grantOpm;
    logic       memIsOk;
    logic       tmoHit;
    logic       grantEnd;
    logic [1:0] grantStatus;

    assign reqAAct  = |reqAOpm;
    assign reqBAct  = |reqBOpm;
    assign inGrant  = (state == GRANT_A) || (state == GRANT_B);
    assign grantOpm = (state == GRANT_B) ? reqBOpm : reqAOpm;
    assign memIsOk  = (memOK == ST_OK);
    // The cycle that would bring tmo to TMO_LIMIT is the one that faults.
    assign tmoHit   = inGrant && !memIsOk && (tmo == TMO_LAST);
    assign grantEnd = (memOK == ST_FAULT) || tmoHit || ((grantOpm == 5'd0) && seenOk);
    assign grantStatus = tmoHit ? ST_FAULT :
                         (memOK == ST_READY) ? ST_HOLD : memOK;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (reqAAct && (!reqBAct || lastWin)) begin
                    nextState = GRANT_A;
                end else if (reqBAct) begin
                    nextState = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (grantEnd) begin
                    nextState = RELEASE;
                end
            end
            RELEASE: begin
                if (memOK == ST_READY) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memAddr  <= 48'd0;
            memOpm   <= 5'd0;
            memDataO <= 128'd0;
            lastWin  <= 1'b1;
            tmo      <= 8'd0;
            seenOk   <= 1'b0;
        end else begin
            if (nextState == GRANT_A) begin
                memAddr  <= reqAAddr;
                memOpm   <= reqAOpm;
                memDataO <= reqADataO;
            end else if (nextState == GRANT_B) begin
                memAddr  <= reqBAddr;
                memOpm   <= reqBOpm;
                memDataO <= reqBDataO;
            end else begin
                memOpm <= 5'd0;
            end

            if (state == IDLE) begin
                tmo    <= 8'd0;
                seenOk <= 1'b0;
                if (nextState == GRANT_A) begin
                    lastWin <= 1'b0;
                end else if (nextState == GRANT_B) begin
                    lastWin <= 1'b1;
                end
            end else if (inGrant) begin
                tmo <= memIsOk ? 8'd0 : tmo + 8'd1;
                if (memIsOk) begin
                    seenOk <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        reqAOK    = reqAAct ? ST_HOLD : ST_READY;
        reqBOK    = reqBAct ? ST_HOLD : ST_READY;
        reqADataI = 128'd0;
        reqBDataI = 128'd0;
        if (state == GRANT_A) begin
            reqAOK    = grantStatus;
            reqADataI = memDataI;
        end else if (state == GRANT_B) begin
            reqBOK    = grantStatus;
            reqBDataI = memDataI;
        end
        // Reset overrides the live memory status so nothing leaks through asynchronously.
        if (!reset) begin
            reqAOK    = ST_READY;
            reqBOK    = ST_READY;
            reqADataI = 128'd0;
            reqBDataI = 128'd0;
        end
    end

endmodule

// File: tb/tb_jx2_mem_arb.sv
// Scoreboard bench for jx2_mem_arb: directed stimulus queues expected memory grants
// and OK/FAULT responses, a negedge monitor pops and compares them.
module tb_jx2_mem_arb;
    localparam logic [1:0] READY = 2'b00;
    localparam logic [1:0] OK    = 2'b01;
    localparam logic [1:0] HOLD  = 2'b10;
    localparam logic [1:0] FAULT = 2'b11;

    logic         clock;
    logic         reset;
    logic [47:0]  reqAAddr, reqBAddr;
    logic [4:0]   reqAOpm, reqBOpm;
    logic [127:0] reqADataO, reqBDataO;
    logic [127:0] reqADataI, reqBDataI;
    logic [1:0]   reqAOK, reqBOK;
    logic [47:0]  memAddr;
    logic [4:0]   memOpm;
    logic [127:0] memDataO;
    logic [127:0] memDataI;
    logic [1:0]   memOK;

    typedef struct {
        logic [4:0]   opm;
        logic [47:0]  addr;
        logic [127:0] data;
    } memExp_t;

    typedef struct {
        logic         isB;
        logic [1:0]   ok;
        logic [127:0] data;
    } okExp_t;

    memExp_t memQ[$];
    okExp_t  okQ[$];

    int checks = 0;
    int errors = 0;
    logic [4:0] prevOpm = 5'd0;

    jx2_mem_arb #(.TMO_LIMIT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .reqAAddr  (reqAAddr),
        .reqBAddr  (reqBAddr),
        .reqAOpm   (reqAOpm),
        .reqBOpm   (reqBOpm),
        .reqADataO (reqADataO),
        .reqBDataO (reqBDataO),
        .reqADataI (reqADataI),
        .reqBDataI (reqBDataI),
        .reqAOK    (reqAOK),
        .reqBOK    (reqBOK),
        .memAddr   (memAddr),
        .memOpm    (memOpm),
        .memDataO  (memDataO),
        .memDataI  (memDataI),
        .memOK     (memOK)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input bit isB, input logic [4:0] opm, input logic [47:0] addr,
                          input logic [127:0] d);
        if (isB) begin
            reqBOpm = opm; reqBAddr = addr; reqBDataO = d;
        end else begin
            reqAOpm = opm; reqAAddr = addr; reqADataO = d;
        end
    endtask

    task automatic chkOk(input bit isB, input logic [1:0] exp, input string name);
        chk(name, isB ? reqBOK : reqAOK, exp);
    endtask

    task automatic pushMem(input logic [4:0] opm, input logic [47:0] addr, input logic [127:0] d);
        memExp_t e;
        e.opm = opm; e.addr = addr; e.data = d;
        memQ.push_back(e);
    endtask

    task automatic pushOk(input bit isB, input logic [1:0] ok, input logic [127:0] d);
        okExp_t e;
        e.isB = isB; e.ok = ok; e.data = d;
        okQ.push_back(e);
    endtask

    // Single-requester transaction from IDLE: holds x HOLD, one OK, drop opm, retire.
    task automatic simpleTxn(input bit isB, input logic [4:0] opm, input logic [47:0] addr,
                             input logic [127:0] wd, input int holds, input logic [127:0] rd);
        setReq(isB, opm, addr, wd);
        pushMem(opm, addr, wd);
        cyc();
        chk("grantLatency", memOpm, opm);
        repeat (holds) begin
            memOK = HOLD;
            #2 chkOk(isB, HOLD, "holdPhase");
            cyc();
        end
        memOK = OK;
        memDataI = rd;
        pushOk(isB, OK, rd);
        cyc();
        setReq(isB, 5'd0, addr, wd);
        memOK = READY;
        memDataI = 128'd0;
        cyc();
        #2;
        chk("releaseOpm", memOpm, 5'd0);
        chkOk(isB, READY, "releaseIdleReq");
        cyc();
        chk("idleHoldAddr", memAddr, addr);
    endtask

    always @(negedge clock) begin
        memExp_t me;
        okExp_t  oe;
        if (memOpm != 5'd0 && prevOpm == 5'd0) begin
            if (memQ.size() == 0) begin
                chk("memGrantUnexpected", memOpm, 5'd0);
            end else begin
                me = memQ.pop_front();
                chk("memGrant", {memOpm, memAddr, memDataO}, {me.opm, me.addr, me.data});
            end
        end
        prevOpm = memOpm;
        if (reqAOK[0]) begin
            if (okQ.size() == 0 || okQ[0].isB) begin
                chk("reqAUnexpected", reqAOK, HOLD);
            end else begin
                oe = okQ.pop_front();
                chk("reqAResp", {reqAOK, reqADataI}, {oe.ok, oe.data});
            end
        end
        if (reqBOK[0]) begin
            if (okQ.size() == 0 || !okQ[0].isB) begin
                chk("reqBUnexpected", reqBOK, HOLD);
            end else begin
                oe = okQ.pop_front();
                chk("reqBResp", {reqBOK, reqBDataI}, {oe.ok, oe.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        memOK = READY;
        memDataI = 128'd0;
        setReq(0, 5'b01111, 48'h1, 128'h1);
        setReq(1, 5'd0, 48'h0, 128'h0);
        #3;
        chk("rstMemOpm", memOpm, 5'd0);
        chk("rstMemAddr", memAddr, 48'd0);
        chk("rstMemDataO", memDataO, 128'd0);
        chk("rstReqAOK", reqAOK, READY);
        chk("rstReqDataI", {reqADataI, reqBDataI}, 256'd0);
        setReq(0, 5'd0, 48'h0, 128'h0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();

        // Tie from reset: A, then B, then A.
        setReq(0, 5'b01111, 48'hA0, 128'hAA);
        setReq(1, 5'b01111, 48'hB0, 128'hBB);
        pushMem(5'b01111, 48'hA0, 128'hAA);
        #2 chk("tieIdleB", reqBOK, HOLD);
        cyc();
        memOK = OK;
        memDataI = 128'hD1;
        pushOk(0, OK, 128'hD1);
        #2;
        chk("tieBHold", reqBOK, HOLD);
        chk("tieBData", reqBDataI, 128'd0);
        cyc();
        setReq(0, 5'd0, 48'hA0, 128'hAA);
        memOK = READY;
        memDataI = 128'd0;
        cyc();
        setReq(0, 5'b01111, 48'hA0, 128'hAA);
        #2;
        chk("tieRelOpm", memOpm, 5'd0);
        chk("tieRelHold", {reqAOK, reqBOK}, {HOLD, HOLD});
        cyc();
        pushMem(5'b01111, 48'hB0, 128'hBB);
        cyc();
        memOK = OK;
        memDataI = 128'hD2;
        pushOk(1, OK, 128'hD2);
        #2 chk("tieAHold", reqAOK, HOLD);
        cyc();
        setReq(1, 5'd0, 48'hB0, 128'hBB);
        memOK = READY;
        memDataI = 128'd0;
        cyc();
        setReq(1, 5'b01111, 48'hB0, 128'hBB);
        cyc();
        pushMem(5'b01111, 48'hA0, 128'hAA);
        cyc();
        memOK = OK;
        memDataI = 128'hD3;
        pushOk(0, OK, 128'hD3);
        cyc();
        setReq(0, 5'd0, 48'hA0, 128'hAA);
        setReq(1, 5'd0, 48'hB0, 128'hBB);
        memOK = READY;
        memDataI = 128'd0;
        cyc();
        cyc();

        // Single read with three HOLD cycles.
        simpleTxn(0, 5'b01111, 48'h000000001230, 128'd0, 3,
                  128'hDEAD0000_00000000_00000000_0000BEEF);

        // Writeback then fill from the same requester.
        simpleTxn(0, 5'b10111, 48'h2000, 128'h1111_2222_3333_4444, 1, 128'd0);
        simpleTxn(0, 5'b01111, 48'h2000, 128'h0, 0, 128'hF00D);

        // Opm change mid-grant is forwarded, no re-arbitration.
        setReq(0, 5'b01111, 48'h3000, 128'h77);
        pushMem(5'b01111, 48'h3000, 128'h77);
        cyc();
        memOK = HOLD;
        setReq(0, 5'b01110, 48'h3000, 128'h77);
        cyc();
        chk("opmForward", memOpm, 5'b01110);
        memOK = OK;
        memDataI = 128'h99;
        pushOk(0, OK, 128'h99);
        cyc();
        setReq(0, 5'd0, 48'h3000, 128'h77);
        memOK = READY;
        memDataI = 128'd0;
        cyc();
        cyc();

        // Watchdog: memory stuck at HOLD, fault on the 4th grant cycle.
        setReq(1, 5'b01111, 48'hB8, 128'h55);
        pushMem(5'b01111, 48'hB8, 128'h55);
        cyc();
        memOK = HOLD;
        for (int i = 0; i < 3; i++) begin
            #2 chkOk(1, HOLD, "tmoHold");
            cyc();
        end
        pushOk(1, FAULT, 128'd0);
        #2 chk("tmoFault", reqBOK, FAULT);
        cyc();
        chk("tmoOpmOff", memOpm, 5'd0);
        #2 chk("tmoRelHold", reqBOK, HOLD);
        cyc();
        chk("tmoRelWait", memOpm, 5'd0);
        cyc();
        chk("tmoRelWait2", memOpm, 5'd0);
        memOK = READY;
        setReq(1, 5'd0, 48'hB8, 128'h55);
        cyc();
        cyc();

        // Reset in the middle of a B grant.
        setReq(1, 5'b01111, 48'hBC, 128'h66);
        pushMem(5'b01111, 48'hBC, 128'h66);
        cyc();
        memOK = HOLD;
        memDataI = 128'hCAFE;
        cyc();
        #2;
        reset = 1'b0;
        #1;
        chk("midRstOpm", memOpm, 5'd0);
        chk("midRstAddr", memAddr, 48'd0);
        chk("midRstDataO", memDataO, 128'd0);
        chk("midRstBOK", reqBOK, READY);
        chk("midRstBData", reqBDataI, 128'd0);
        cyc();
        memOK = READY;
        memDataI = 128'd0;
        setReq(0, 5'b01111, 48'hA4, 128'h44);
        chk("midRstAOK", reqAOK, READY);
        cyc();
        reset = 1'b1;
        pushMem(5'b01111, 48'hA4, 128'h44);
        cyc();
        chk("postRstTieA", memAddr, 48'hA4);
        memOK = OK;
        memDataI = 128'h4242;
        pushOk(0, OK, 128'h4242);
        cyc();
        setReq(0, 5'd0, 48'hA4, 128'h44);
        setReq(1, 5'd0, 48'hBC, 128'h66);
        memOK = READY;
        memDataI = 128'd0;
        cyc();
        cyc();
        cyc();

        chk("memQEmpty", memQ.size(), 0);
        chk("okQEmpty", okQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jx2_mem_arb.md
JX2_MEM_ARB -- requirements
Module: jx2_mem_arb

Interface
REQ-001 SHALL have parameter TMO_LIMIT, default 255, meaning the number of grant cycles without a memory OK before a fault is reported (range 1..255).
REQ-002 SHALL have port clock  in  1  the single clock; all state changes on posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports reqAAddr/reqBAddr  in  48  requester address (A = data cache, B = instruction cache).
REQ-005 SHALL have ports reqAOpm/reqBOpm  in  5  requester OPM {WR,OE,Z0,S1,S0}; 0 = no request.
REQ-006 SHALL have ports reqADataO/reqBDataO  in  128  requester store data.
REQ-007 SHALL have ports reqADataI/reqBDataI  out  128  load data returned to the requester.
REQ-008 SHALL have ports reqAOK/reqBOK  out  2  status: READY=00, OK=01, HOLD=10, FAULT=11.
REQ-009 SHALL have ports memAddr  out  48, memOpm  out  5, memDataO  out  128: shared memory request.
REQ-010 SHALL have ports memDataI  in  128 and memOK  in  2: shared memory response, same encoding as REQ-008.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT_A, GRANT_B and RELEASE; plus a 1-bit lastWin and an 8-bit watchdog counter tmo.
REQ-012 IDLE behaviour:
- Only A opm!=0 -> GRANT_A; only B opm!=0 -> GRANT_B.
- Both nonzero -> grant the requester not equal to lastWin.
- lastWin updates at grant time.
REQ-013 In GRANT_x, memAddr/memOpm/memDataO SHALL register the granted requester's inputs every cycle (one-cycle latency from requester input to memory port).
REQ-014 In GRANT_x, reqxOK SHALL follow memOK combinationally, with one exception: memOK=READY SHALL be shown as HOLD; reqxDataI SHALL equal memDataI.
REQ-015 The non-granted requester SHALL see HOLD when its opm!=0, else READY; its DataI SHALL be 0.
REQ-016 GRANT_x SHALL move to RELEASE when:
- granted opm becomes 0 after at least one memOK=OK was seen, or
- memOK=FAULT (forwarded to the requester that cycle).
REQ-017 In RELEASE, memOpm SHALL be 0 and both requesters SHALL see HOLD if requesting, else READY.
REQ-018 RELEASE SHALL return to IDLE on the first cycle memOK=READY, so the memory side has retired before the next grant.
REQ-019 tmo SHALL clear on entry to GRANT_x and on any memOK=OK, and SHALL increment each GRANT_x cycle otherwise.
REQ-020 When tmo reaches TMO_LIMIT:
- reqxOK SHALL be FAULT for exactly one cycle;
- memOpm SHALL be driven 0 at the next edge;
- the FSM SHALL go to RELEASE.
REQ-021 A requester changing opm to a different nonzero value while granted SHALL be forwarded unchanged and SHALL NOT cause a re-arbitration.
REQ-022 In IDLE, memOpm SHALL be 0, and memAddr/memDataO SHALL hold their last values.
REQ-023 The arbiter SHALL never forward two requesters in the same cycle, and SHALL never change the grant while memOK=HOLD or OK.

Reset
REQ-024 While reset=0, regardless of clock, the block SHALL force:
- state IDLE, lastWin=B, tmo=0;
- memOpm=0, memAddr=0, memDataO=0;
- reqAOK=reqBOK=READY, reqADataI=reqBDataI=0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction without emitting OK or FAULT; after release, arbitration SHALL restart from IDLE with A winning a tie.

Verification
REQ-026 Single read: A opm=01111, addr 0x000000001230; memory gives HOLD x3 then OK with data 0xDEAD..BEEF -> memOpm=01111 one cycle after the request, reqAOK=HOLD x3 then OK with data; A drops opm; memOK=READY -> IDLE.
REQ-027 Tie and fairness: A and B request in the same cycle from reset -> A granted and B sees HOLD; after A completes with both still requesting -> B granted next, then A.
REQ-028 Watchdog: TMO_LIMIT=4, B request, memOK stuck HOLD -> reqBOK=FAULT on the 4th grant cycle for exactly one cycle, memOpm=0 at the next edge, FSM waits in RELEASE until memOK=READY.
REQ-029 Writeback then fill: A issues 10111 (write), OK, opm 0, then 01111 (read) -> two separate grants, each separated by a RELEASE cycle with memOpm=0.
REQ-030 Reset mid-op: reset low during GRANT_B with memOK=HOLD -> all outputs at reset values immediately (asynchronously), no OK pulse on reqBOK; after release, a tie grants A.
